// File: rtl/mac_pack.sv
// Serial byte packer: bytes are appended into slots 0..NB-1 of a wide word (slot 0 in the top byte),
// and the word is held for the consumer once it is full or a flush closes it early.
module mac_pack #(
  parameter int NB = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [8*NB-1:0]       out_data,
  output logic [$clog2(NB):0]   out_count,
  input  logic                  out_ready
);

  localparam int IW = $clog2(NB);
  localparam int CW = IW + 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    slot_reg [NB];

  logic accept;
  logic last;
  logic take;

  assign in_ready  = (state_reg == FILL);
  assign out_valid = (state_reg == HOLD);
  assign out_count = count_reg;

  assign accept = in_valid & in_ready;
  assign last   = (idx_reg == IW'(NB - 1));
  assign take   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept && (last || flush)) begin
            // A flush that coincides with an accept closes the word including that byte.
            state_reg <= HOLD;
            count_reg <= last ? CW'(NB) : (CW'(idx_reg) + CW'(1));
            idx_reg   <= '0;
          end else if (accept) begin
            idx_reg <= idx_reg + IW'(1);
          end else if (flush && (idx_reg != '0)) begin
            state_reg <= HOLD;
            count_reg <= CW'(idx_reg);
            idx_reg   <= '0;
          end
        end
        default: begin
          if (out_ready) begin
            state_reg <= FILL;
            count_reg <= '0;
            idx_reg   <= '0;
          end
        end
      endcase
    end
  end

  // Each slot clears when its word is taken so a later partial word reads zero in unwritten slots.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst || take) begin
          slot_reg[gi] <= '0;
        end else if (accept && (idx_reg == IW'(gi))) begin
          slot_reg[gi] <= in_data;
        end
      end
      assign out_data[8*NB-1-8*gi -: 8] = slot_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_mac_pack.sv
// Directed and randomized checks of mac_pack at NB=16, plus scoreboard sweeps at NB=4 and NB=64.
module tb_mac_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // NB=16 instance for directed vectors
  logic         rst, in_valid, flush, out_ready;
  logic [7:0]   in_data;
  logic         in_ready, out_valid;
  logic [127:0] out_data;
  logic [4:0]   out_count;

  mac_pack #(.NB(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_ready(out_ready)
  );

  // NB=4 and NB=64 instances for the random sweep
  logic        a_in_valid, a_out_ready, a_in_ready, a_out_valid;
  logic [7:0]  a_in_data;
  logic [31:0] a_out_data;
  logic [2:0]  a_out_count;
  logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid;
  logic [7:0]  b_in_data;
  logic [511:0] b_out_data;
  logic [6:0]  b_out_count;

  mac_pack #(.NB(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .flush(1'b0), .out_valid(a_out_valid), .out_data(a_out_data), .out_count(a_out_count),
    .out_ready(a_out_ready)
  );

  mac_pack #(.NB(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .flush(1'b0), .out_valid(b_out_valid), .out_data(b_out_data), .out_count(b_out_count),
    .out_ready(b_out_ready)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  logic [127:0] exp_word;
  logic [127:0] held;
  logic [7:0]   q4[$];
  logic [7:0]   q64[$];
  logic [511:0] e4;
  logic [511:0] e64;
  int           words4;
  int           words64;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", 512'(in_ready), 512'(1));
    chk("reset_out_valid", 512'(out_valid), 512'(0));
    chk("reset_out_count", 512'(out_count), 512'(0));
    chk("reset_out_data", 512'(out_data), 512'(0));

    // Full word 0x00..0x0F
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      if (i < 15) chk($sformatf("full_no_valid_%0d", i), 512'(out_valid), 512'(0));
    end
    out_ready = 1'b0;
    chk("full_valid", 512'(out_valid), 512'(1));
    chk("full_in_ready", 512'(in_ready), 512'(0));
    chk("full_data", 512'(out_data), 512'(128'h000102030405060708090A0B0C0D0E0F));
    chk("full_count", 512'(out_count), 512'(16));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("full_back_fill", 512'(in_ready), 512'(1));
    chk("full_cleared_valid", 512'(out_valid), 512'(0));
    chk("full_cleared_count", 512'(out_count), 512'(0));
    chk("full_cleared_data", 512'(out_data), 512'(0));

    // Backpressure: word of 0x20..0x2F held for 5 cycles
    exp_word = '0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(8'h20 + i));
      exp_word[127-8*i -: 8] = 8'(8'h20 + i);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'h99;
      flush    = 1'b1;
      chk($sformatf("bp_valid_%0d", c), 512'(out_valid), 512'(1));
      chk($sformatf("bp_in_ready_%0d", c), 512'(in_ready), 512'(0));
      chk($sformatf("bp_data_%0d", c), 512'(out_data), 512'(exp_word));
      chk($sformatf("bp_count_%0d", c), 512'(out_count), 512'(16));
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_taken", 512'(out_valid), 512'(0));

    // Partial flush AA BB CC
    push_byte(8'hAA);
    push_byte(8'hBB);
    push_byte(8'hCC);
    chk("pf_not_yet", 512'(out_valid), 512'(0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pf_valid", 512'(out_valid), 512'(1));
    chk("pf_count", 512'(out_count), 512'(3));
    chk("pf_data", 512'(out_data), 512'({24'hAABBCC, 104'h0}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    push_byte(8'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pf_next_count", 512'(out_count), 512'(1));
    chk("pf_next_data", 512'(out_data), 512'({8'h77, 120'h0}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush with empty word is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fe_no_valid", 512'(out_valid), 512'(0));
    chk("fe_in_ready", 512'(in_ready), 512'(1));
    step();
    chk("fe_still_no_valid", 512'(out_valid), 512'(0));

    // Flush coincident with the 5th byte
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    flush = 1'b1;
    push_byte(8'h55);
    flush = 1'b0;
    chk("fc_valid", 512'(out_valid), 512'(1));
    chk("fc_count", 512'(out_count), 512'(5));
    chk("fc_data", 512'(out_data), 512'({40'h1122334455, 88'h0}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset in the middle of a fill
    for (int i = 0; i < 7; i++) push_byte(8'(8'hE0 + i));
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; flush = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    chk("mr_in_ready", 512'(in_ready), 512'(1));
    chk("mr_out_valid", 512'(out_valid), 512'(0));
    chk("mr_out_data", 512'(out_data), 512'(0));
    exp_word = '0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(8'h10 + i));
      exp_word[127-8*i -: 8] = 8'(8'h10 + i);
    end
    chk("mr_valid", 512'(out_valid), 512'(1));
    chk("mr_data", 512'(out_data), 512'(exp_word));
    chk("mr_count", 512'(out_count), 512'(16));

    // Reset discards a held word that was never taken
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hr_out_valid", 512'(out_valid), 512'(0));
    chk("hr_out_data", 512'(out_data), 512'(0));
    chk("hr_out_count", 512'(out_count), 512'(0));

    // Random sweep at NB=4 and NB=64 against byte-order scoreboards
    words4 = 0;
    words64 = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      a_in_valid  = 1'($urandom_range(1));
      a_out_ready = 1'($urandom_range(1));
      a_in_data   = 8'($urandom);
      b_in_valid  = 1'($urandom_range(1));
      b_out_ready = 1'($urandom_range(1));
      b_in_data   = 8'($urandom);
      if (a_in_valid && a_in_ready) q4.push_back(a_in_data);
      if (b_in_valid && b_in_ready) q64.push_back(b_in_data);
      if (a_out_valid && a_out_ready) begin
        e4 = '0;
        if (q4.size() < 4) begin
          chk("rs4_underflow", 512'(q4.size()), 512'(4));
        end else begin
          for (int k = 0; k < 4; k++) e4[31-8*k -: 8] = q4.pop_front();
          chk($sformatf("rs4_data_%0d", words4), 512'(a_out_data), e4);
          chk($sformatf("rs4_count_%0d", words4), 512'(a_out_count), 512'(4));
        end
        words4++;
      end
      if (b_out_valid && b_out_ready) begin
        e64 = '0;
        if (q64.size() < 64) begin
          chk("rs64_underflow", 512'(q64.size()), 512'(64));
        end else begin
          for (int k = 0; k < 64; k++) e64[511-8*k -: 8] = q64.pop_front();
          chk($sformatf("rs64_data_%0d", words64), b_out_data, e64);
          chk($sformatf("rs64_count_%0d", words64), 512'(b_out_count), 512'(64));
        end
        words64++;
      end
      step();
    end
    chk("rs4_progress", 512'(words4 > 100), 512'(1));
    chk("rs64_progress", 512'(words64 > 5), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
